// File: rtl/lcd_text_engine.sv
// HD44780 character LCD controller: self-running power-on init, packed multi-character
// or raw command writes, full bus timing and cursor tracking with automatic line wrap.
module lcd_text_engine #(
  parameter int BYTES        = 4,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 12,
  parameter int CMD_WAIT     = 2000,
  parameter int CLEAR_WAIT   = 82000,
  parameter int INIT_WAIT    = 750000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*BYTES-1:0]      data,
  input  logic                    selectCD,
  input  logic                    enableWriting,
  output logic                    LCD_Available,
  output logic [7:0]              LCD_DATA,
  output logic                    LCD_RS,
  output logic                    LCD_RW,
  output logic                    LCD_EN,
  output logic                    LCD_ON,
  output logic                    LCD_BLON,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    cursor_row
);

  localparam int COL_W   = $clog2(COLS);
  localparam int MAX_A   = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
  localparam int MAX_B   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
  localparam int MAX_C   = (MAX_B > SETUP_CYCLES) ? MAX_B : SETUP_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT - 1);
  localparam logic [COL_W:0]   COL_END    = (COL_W + 1)'(COLS);

  localparam logic [2:0] S_POWER_WAIT = 3'd0;
  localparam logic [2:0] S_INIT       = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_LOAD       = 3'd3;
  localparam logic [2:0] S_SETUP      = 3'd4;
  localparam logic [2:0] S_PULSE      = 3'd5;
  localparam logic [2:0] S_HOLD       = 3'd6;
  localparam logic [2:0] S_WRAP       = 3'd7;

  // What the byte currently on the bus is, so HOLD knows what follows it.
  localparam logic [1:0] K_INIT = 2'd0;
  localparam logic [1:0] K_CHAR = 2'd1;
  localparam logic [1:0] K_CMD  = 2'd2;
  localparam logic [1:0] K_WRAP = 2'd3;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8*BYTES-1:0] word_q, word_d;
  logic               cmd_mode_q, cmd_mode_d;
  logic [1:0]         kind_q, kind_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         bus_q, bus_d;
  logic               rs_q, rs_d;
  logic               en_q, en_d;
  logic               avail_q, avail_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               row_q, row_d;

  logic               nz_found;
  logic [7:0]         nz_byte;
  logic [8*BYTES-1:0] nz_rest;
  logic               take_next;
  logic               clear_cmd;
  logic               col_wraps;
  logic               wrap_to_row1;
  logic [CNT_W-1:0]   hold_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h80;
    endcase
  endfunction

  // Consumed bytes are zeroed in word_q, so the first non-zero byte from the MSB is always
  // the next character to send; zero padding is skipped for free.
  always_comb begin
    nz_found = 1'b0;
    nz_byte  = 8'h00;
    nz_rest  = word_q;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (!nz_found && word_q[8*i +: 8] != 8'h00) begin
        nz_found           = 1'b1;
        nz_byte            = word_q[8*i +: 8];
        nz_rest[8*i +: 8]  = 8'h00;
      end
    end
  end

  assign clear_cmd    = !rs_q && (bus_q == 8'h01 || bus_q == 8'h02);
  assign hold_last    = clear_cmd ? CLEAR_LAST : CMD_LAST;
  assign col_wraps    = ({1'b0, col_q} + 1'b1) == COL_END;
  assign wrap_to_row1 = (ROWS > 1) && !row_q;

  // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    cmd_mode_d = cmd_mode_q;
    kind_d     = kind_q;
    idx_d      = idx_q;
    bus_d      = bus_q;
    rs_d       = rs_q;
    en_d       = en_q;
    avail_d    = avail_q;
    col_d      = col_q;
    row_d      = row_q;
    take_next  = 1'b0;

    case (state_q)
      S_POWER_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          bus_d   = init_cmd(3'd0);
          rs_d    = 1'b0;
          kind_d  = K_INIT;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INIT, S_SETUP, S_WRAP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q != hold_last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (kind_q)
            K_INIT: begin
              if (idx_q == 3'd4) begin
                state_d = S_IDLE;
                avail_d = 1'b1;
              end else begin
                idx_d   = idx_q + 3'd1;
                bus_d   = init_cmd(idx_q + 3'd1);
                state_d = S_INIT;
              end
            end
            K_CMD: begin
              if (clear_cmd) begin
                col_d = '0;
                row_d = 1'b0;
              end else if (bus_q[7]) begin
                row_d = (ROWS > 1) ? bus_q[6] : 1'b0;
                col_d = COL_W'(bus_q[5:0]);
              end
              state_d = S_IDLE;
              avail_d = 1'b1;
            end
            K_CHAR: begin
              if (col_wraps) begin
                col_d   = '0;
                row_d   = wrap_to_row1;
                bus_d   = wrap_to_row1 ? 8'hC0 : 8'h80;
                rs_d    = 1'b0;
                kind_d  = K_WRAP;
                state_d = S_WRAP;
              end else begin
                col_d     = col_q + 1'b1;
                take_next = 1'b1;
              end
            end
            default: take_next = 1'b1;
          endcase
        end
      end
      S_IDLE: begin
        if (enableWriting) begin
          word_d     = data;
          cmd_mode_d = !selectCD;
          avail_d    = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cmd_mode_q) begin
          bus_d   = word_q[7:0];
          rs_d    = 1'b0;
          kind_d  = K_CMD;
          state_d = S_SETUP;
        end else begin
          take_next = 1'b1;
        end
      end
      default: state_d = S_POWER_WAIT;
    endcase

    // Shared by LOAD and the end of each character/wrap transfer.
    if (take_next) begin
      if (nz_found) begin
        bus_d   = nz_byte;
        rs_d    = 1'b1;
        word_d  = nz_rest;
        kind_d  = K_CHAR;
        state_d = S_SETUP;
      end else begin
        state_d = S_IDLE;
        avail_d = 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_POWER_WAIT;
      cnt_q      <= '0;
      word_q     <= '0;
      cmd_mode_q <= 1'b0;
      kind_q     <= K_INIT;
      idx_q      <= 3'd0;
      bus_q      <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      avail_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      cmd_mode_q <= cmd_mode_d;
      kind_q     <= kind_d;
      idx_q      <= idx_d;
      bus_q      <= bus_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      avail_q    <= avail_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign LCD_Available = avail_q;
  assign LCD_DATA      = bus_q;
  assign LCD_RS        = rs_q;
  assign LCD_EN        = en_q;
  assign LCD_RW        = 1'b0;
  assign LCD_ON        = 1'b1;
  assign LCD_BLON      = 1'b1;
  assign cursor_col    = col_q;
  assign cursor_row    = row_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// Self-checking bench for lcd_text_engine: bus monitor, request-level reference model,
// directed vector table, wrap/re-accept/reset sequences and randomized requests.
module tb_lcd_text_engine;

  localparam int BYTES        = 4;
  localparam int COLS         = 16;
  localparam int ROWS         = 2;
  localparam int SETUP_CYCLES = 1;
  localparam int EN_CYCLES    = 2;
  localparam int CMD_WAIT     = 4;
  localparam int CLEAR_WAIT   = 10;
  localparam int INIT_WAIT    = 20;
  localparam int XFER         = SETUP_CYCLES + EN_CYCLES;
  localparam int INIT_TOTAL   = INIT_WAIT + 5 * XFER + 4 * CMD_WAIT + CLEAR_WAIT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        sel_in = 1'b0;
  logic        we = 1'b0;
  logic        LCD_Available, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
  logic [7:0]  LCD_DATA;
  logic [3:0]  cursor_col;
  logic        cursor_row;

  always #5 clk = ~clk;

  lcd_text_engine #(
    .BYTES(BYTES), .COLS(COLS), .ROWS(ROWS), .SETUP_CYCLES(SETUP_CYCLES),
    .EN_CYCLES(EN_CYCLES), .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT), .INIT_WAIT(INIT_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .data(data_in), .selectCD(sel_in), .enableWriting(we),
    .LCD_Available(LCD_Available), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus monitor: records {RS,DATA} at every EN rise, checks setup, stability and EN width.
  logic [8:0] mon_q[$];
  logic [8:0] rise_bus = '0;
  logic [8:0] prev_bus = '0;
  logic       en_prev = 1'b0;
  int         en_run = 0;
  time        last_fall = 0;

  always @(negedge clk) begin
    if (!rst) begin
      en_prev  = 1'b0;
      en_run   = 0;
      prev_bus = '0;
    end else begin
      if (LCD_EN && !en_prev) begin
        rise_bus = {LCD_RS, LCD_DATA};
        mon_q.push_back(rise_bus);
        check("bus_setup", {23'd0, rise_bus}, {23'd0, prev_bus});
        en_run = 1;
      end else if (LCD_EN) begin
        en_run++;
        check("bus_stable_en", {23'd0, LCD_RS, LCD_DATA}, {23'd0, rise_bus});
      end else if (en_prev) begin
        check("en_width", en_run, EN_CYCLES);
        last_fall = $time;
      end
      en_prev  = LCD_EN;
      prev_bus = {LCD_RS, LCD_DATA};
    end
  end

  // Reference model: request -> list of bus bytes, busy length and cursor.
  logic [8:0] exp_q[$];
  int mcol = 0;
  int mrow = 0;

  task automatic model_push(input logic rs, input logic [7:0] b, inout int busy, output int w);
    exp_q.push_back({rs, b});
    w = (!rs && (b == 8'h01 || b == 8'h02)) ? CLEAR_WAIT : CMD_WAIT;
    busy += XFER + w;
  endtask

  task automatic model_request(input logic [31:0] d, input logic sel,
                               output int busy, output int last_wait);
    logic [7:0] b;
    busy = 1;
    last_wait = 0;
    exp_q.delete();
    if (!sel) begin
      b = d[7:0];
      model_push(1'b0, b, busy, last_wait);
      if (b == 8'h01 || b == 8'h02) begin
        mcol = 0;
        mrow = 0;
      end else if (b >= 8'h80) begin
        mrow = (ROWS > 1) ? int'(b[6]) : 0;
        mcol = int'(b[5:0]) % COLS;
      end
    end else begin
      for (int i = BYTES - 1; i >= 0; i--) begin
        b = 8'((d >> (8 * i)) & 32'hFF);
        if (b == 8'h00) continue;
        model_push(1'b1, b, busy, last_wait);
        mcol++;
        if (mcol == COLS) begin
          mcol = 0;
          model_push(1'b0, (ROWS > 1 && mrow == 0) ? 8'hC0 : 8'h80, busy, last_wait);
          mrow = (ROWS > 1) ? 1 - mrow : 0;
        end
      end
    end
  endtask

  task automatic wait_avail();
    int g = 0;
    while (!LCD_Available && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (!LCD_Available) check("wait_avail_timeout", 32'd0, 32'd1);
  endtask

  // One request through the handshake; compares bus bytes, busy length and cursor to the model.
  task automatic do_req(input logic [31:0] d, input logic sel, input bit noisy, output int busy);
    int exp_busy, exp_wait;
    time t_av;
    model_request(d, sel, exp_busy, exp_wait);
    wait_avail();
    mon_q.delete();
    data_in = d;
    sel_in  = sel;
    we      = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    busy = 0;
    while (!LCD_Available && busy < 5000) begin
      busy++;
      if (noisy) begin
        we      = 1'($urandom_range(0, 1));
        data_in = $urandom;
        sel_in  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    we   = 1'b0;
    t_av = $time;
    check("req_busy", busy, exp_busy);
    check("req_npulse", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check($sformatf("req_pulse%0d", i), {23'd0, mon_q[i]}, {23'd0, exp_q[i]});
    check("req_col", {28'd0, cursor_col}, mcol);
    check("req_row", {31'd0, cursor_row}, mrow);
    if (exp_q.size() > 0) check("req_hold_tail", 32'((t_av - last_fall) / 10), exp_wait);
  endtask

  task automatic init_check(input string tag);
    int cyc = 0;
    logic [7:0] init_bytes [5];
    init_bytes = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    while (!LCD_Available && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_init_cycles"}, cyc, INIT_TOTAL);
    check({tag, "_init_npulse"}, mon_q.size(), 5);
    for (int i = 0; i < 5 && i < mon_q.size(); i++)
      check($sformatf("%s_init_cmd%0d", tag, i), {23'd0, mon_q[i]}, {24'd0, init_bytes[i]});
    check({tag, "_init_col"}, {28'd0, cursor_col}, 0);
    check({tag, "_init_row"}, {31'd0, cursor_row}, 0);
    mcol = 0;
    mrow = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, LCD_DATA}, 0);
    check({tag, "_rs"}, {31'd0, LCD_RS}, 0);
    check({tag, "_en"}, {31'd0, LCD_EN}, 0);
    check({tag, "_avail"}, {31'd0, LCD_Available}, 0);
    check({tag, "_rw_on_blon"}, {29'd0, LCD_RW, LCD_ON, LCD_BLON}, 32'b011);
    check({tag, "_cursor"}, {27'd0, cursor_row, cursor_col}, 0);
  endtask

  typedef struct {
    logic [31:0] d;
    logic        sel;
    int          np;
    int          col;
    int          row;
    int          busy;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int busy;
    logic [31:0] w;

    vecs[0]  = '{32'h48454C4C, 1'b1, 4,  4, 0, 29};  // "HELL"
    vecs[1]  = '{32'h004C4C21, 1'b1, 3,  7, 0, 22};  // leading zero skipped
    vecs[2]  = '{32'h00000000, 1'b1, 0,  7, 0,  1};  // no bus activity
    vecs[3]  = '{32'h00000001, 1'b0, 1,  0, 0, 14};  // clear display
    vecs[4]  = '{32'h000000C5, 1'b0, 1,  5, 1,  8};  // DDRAM address row 1 col 5
    vecs[5]  = '{32'h0000000C, 1'b0, 1,  5, 1,  8};  // cursor unchanged
    vecs[6]  = '{32'h00000002, 1'b0, 1,  0, 0, 14};  // return home
    vecs[7]  = '{32'h000000FF, 1'b0, 1, 15, 1,  8};  // column truncated to 15
    vecs[8]  = '{32'h0000005A, 1'b1, 2,  0, 0, 15};  // last cell -> wrap 0x80
    vecs[9]  = '{32'h41000042, 1'b1, 2,  2, 0, 15};  // inner zeros skipped
    vecs[10] = '{32'hFFFFFF06, 1'b0, 1,  2, 0,  8};  // only low byte used in command mode

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    init_check("por");

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].d, vecs[i].sel, 1'b0, busy);
      check($sformatf("tbl%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("tbl%0d_npulse", i), mon_q.size(), vecs[i].np);
      check($sformatf("tbl%0d_col", i), {28'd0, cursor_col}, vecs[i].col);
      check($sformatf("tbl%0d_row", i), {31'd0, cursor_row}, vecs[i].row);
    end

    // 32 characters from home: 0xC0 after the 16th, 0x80 after the 32nd.
    do_req(32'h00000001, 1'b0, 1'b0, busy);
    for (int k = 0; k < 8; k++) begin
      w = 32'h41424344 + 32'h04040404 * k;
      do_req(w, 1'b1, 1'b0, busy);
      if (k == 3) begin
        check("wrap1_last", {23'd0, (mon_q.size() > 0) ? mon_q[$] : 9'h1FF}, 32'h0C0);
        check("wrap1_cursor", {27'd0, cursor_row, cursor_col}, 32'h10);
      end
      if (k == 7) begin
        check("wrap2_last", {23'd0, (mon_q.size() > 0) ? mon_q[$] : 9'h1FF}, 32'h080);
        check("wrap2_cursor", {27'd0, cursor_row, cursor_col}, 32'h00);
      end
    end

    // enableWriting held high: a new request is taken on the first IDLE cycle.
    wait_avail();
    mon_q.delete();
    data_in = '0;
    sel_in  = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    check("held_busy1", {31'd0, LCD_Available}, 0);
    @(negedge clk);
    check("held_idle", {31'd0, LCD_Available}, 1);
    @(negedge clk);
    check("held_reaccept", {31'd0, LCD_Available}, 0);
    we = 1'b0;
    @(negedge clk);
    check("held_done", {31'd0, LCD_Available}, 1);
    check("held_no_bus", mon_q.size(), 0);

    // Randomized requests with enableWriting and data toggling while busy.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] d;
      logic        s;
      s = ($urandom_range(0, 3) != 0);
      d = '0;
      if (s) begin
        for (int b = 0; b < 4; b++)
          d[8*b +: 8] = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom_range(1, 255));
      end else begin
        case ($urandom_range(0, 3))
          0:       d = {$urandom, 8'h01} >> 0;
          1:       d = 32'h00000002;
          2:       d = {24'd0, 1'b1, 7'($urandom_range(0, 127))};
          default: d = $urandom;
        endcase
        if (d[7:0] == 8'h00) d[7:0] = 8'h0C;
      end
      do_req(d, s, 1'b1, busy);
    end

    // Reset in the middle of an EN pulse.
    wait_avail();
    mon_q.delete();
    data_in = 32'h48454C4C;
    sel_in  = 1'b1;
    we      = 1'b1;
    @(negedge clk);
    we = 1'b0;
    for (int g = 0; g < 200 && !LCD_EN; g++) @(negedge clk);
    check("midrst_en_seen", {31'd0, LCD_EN}, 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    mon_q.delete();
    rst = 1'b1;
    init_check("midrst");
    do_req(32'h48454C4C, 1'b1, 1'b0, busy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
